// File: rtl/jk_updown_counter_if.sv
`default_nettype none
// ============================================================================
// jk_updown_counter_if : control/status bundle for the JK up/down counter
// Revision 1.0
// ============================================================================
interface jk_updown_counter_if #(
  parameter int W = 4
);
  logic         En;
  logic         up;
  logic         load;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         tc;
  logic         wrap;

  modport master (
    output En, up, load, D,
    input  Q, tc, wrap
  );

  modport slave (
    input  En, up, load, D,
    output Q, tc, wrap
  );
endinterface
`default_nettype wire

// File: rtl/jk_updown_counter.sv
`default_nettype none
// ============================================================================
// jk_updown_counter : modulo-MOD up/down counter built from a JK flip-flop bank
// Revision 1.0
// ============================================================================
module jk_updown_counter #(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic               CLK,
  input  logic               reset,
  jk_updown_counter_if.slave bus
);

  localparam logic [W:0]   c_MOD = (W+1)'(MOD);
  localparam logic [W-1:0] c_MAX = W'(MOD - 1);

  logic [W-1:0] w_q;
  logic [W-1:0] w_load_val;
  logic [W-1:0] w_up_t;
  logic [W-1:0] w_dn_t;
  logic [W-1:0] w_tgt;
  logic [W-1:0] w_j;
  logic [W-1:0] w_k;
  logic         w_in_range;
  logic         w_at_top;
  logic         w_at_zero;
  logic         w_count_wrap;
  logic         w_wrap_nxt;
  logic         r_wrap;

  assign w_in_range   = ({1'b0, w_q} < c_MOD);
  assign w_at_top     = (w_q == c_MAX);
  assign w_at_zero    = (w_q == '0);
  assign w_load_val   = ({1'b0, bus.D} < c_MOD) ? bus.D : '0;
  assign w_count_wrap = !w_in_range || (bus.up ? w_at_top : w_at_zero);

  // Only a legal down-wrap lands on MOD-1; every other wrap (incl. illegal states) lands on 0.
  assign w_tgt = (!bus.up && w_in_range) ? c_MAX : '0;

  always_comb begin
    logic up_c;
    logic dn_c;
    w_up_t = '0;
    w_dn_t = '0;
    up_c   = 1'b1;
    dn_c   = 1'b1;
    for (int i = 0; i < W; i++) begin
      w_up_t[i] = up_c;
      w_dn_t[i] = dn_c;
      up_c      = up_c & w_q[i];
      dn_c      = dn_c & ~w_q[i];
    end
  end

  always_comb begin
    w_j        = '0;
    w_k        = '0;
    w_wrap_nxt = 1'b0;
    if (bus.load) begin
      w_j = w_load_val;
      w_k = ~w_load_val;
    end else if (bus.En) begin
      if (w_count_wrap) begin
        w_j        = w_tgt;
        w_k        = ~w_tgt;
        w_wrap_nxt = 1'b1;
      end else if (bus.up) begin
        w_j = w_up_t;
        w_k = w_up_t;
      end else begin
        w_j = w_dn_t;
        w_k = w_dn_t;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_jk
      logic r_qb;
      always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
          r_qb <= 1'b0;
        end else begin
          case ({w_j[gi], w_k[gi]})
            2'b01:   r_qb <= 1'b0;
            2'b10:   r_qb <= 1'b1;
            2'b11:   r_qb <= ~r_qb;
            default: r_qb <= r_qb;
          endcase
        end
      end
      assign w_q[gi] = r_qb;
    end
  endgenerate

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.Q    = w_q;
  assign bus.wrap = r_wrap;
  assign bus.tc   = bus.En & ~bus.load & (bus.up ? w_at_top : w_at_zero);

endmodule
`default_nettype wire

// File: tb/tb_jk_updown_counter.sv
`default_nettype none
// ============================================================================
// tb_jk_updown_counter : directed checks of the decade JK counter and a cascade
// Revision 1.0
// ============================================================================
module tb_jk_updown_counter;

  logic CLK;
  logic reset;
  int   n_vec;
  int   n_err;

  jk_updown_counter_if #(.W(4)) u_if ();
  jk_updown_counter_if #(.W(4)) u_lo ();
  jk_updown_counter_if #(.W(4)) u_hi ();

  jk_updown_counter #(.W(4), .MOD(10)) u_dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (u_if.slave)
  );

  jk_updown_counter #(.W(4), .MOD(10)) u_dut_lo (
    .CLK   (CLK),
    .reset (reset),
    .bus   (u_lo.slave)
  );

  jk_updown_counter #(.W(4), .MOD(10)) u_dut_hi (
    .CLK   (CLK),
    .reset (reset),
    .bus   (u_hi.slave)
  );

  assign u_hi.En = u_lo.tc;
  assign u_hi.up = u_lo.up;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_q;
    int         cnt;
    int         hi_wraps;
    logic [3:0] up_seq [12];
    logic [3:0] dn_seq [4];
    up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    dn_seq = '{4'd1, 4'd0, 4'd9, 4'd8};
    n_vec = 0;
    n_err = 0;

    reset     = 1'b1;
    u_if.En   = 1'b0;
    u_if.up   = 1'b0;
    u_if.load = 1'b0;
    u_if.D    = '0;
    u_lo.En   = 1'b0;
    u_lo.up   = 1'b1;
    u_lo.load = 1'b0;
    u_lo.D    = '0;
    u_hi.load = 1'b0;
    u_hi.D    = '0;
    repeat (2) step();
    chk("rst_q", 8'(u_if.Q), 8'd0);
    chk("rst_wrap", 8'(u_if.wrap), 8'd0);
    chk("rst_tc", 8'(u_if.tc), 8'd0);
    reset = 1'b0;

    // Asynchronous reset lands mid-cycle, then holds even with En=1
    u_if.load = 1'b1;
    u_if.D    = 4'd7;
    step();
    chk("load7_q", 8'(u_if.Q), 8'd7);
    u_if.load = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_q", 8'(u_if.Q), 8'd0);
    chk("async_rst_wrap", 8'(u_if.wrap), 8'd0);
    u_if.En = 1'b1;
    u_if.up = 1'b1;
    step();
    step();
    chk("rst_hold_q", 8'(u_if.Q), 8'd0);
    chk("rst_hold_wrap", 8'(u_if.wrap), 8'd0);
    reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      step();
      exp_q = 8'(up_seq[k]);
      chk("up_q", 8'(u_if.Q), exp_q);
      chk("up_tc", 8'(u_if.tc), 8'(exp_q == 8'd9));
      chk("up_wrap", 8'(u_if.wrap), 8'(k == 9));
    end

    u_if.up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_q = 8'(dn_seq[k]);
      chk("dn_q", 8'(u_if.Q), exp_q);
      chk("dn_tc", 8'(u_if.tc), 8'(exp_q == 8'd0));
      chk("dn_wrap", 8'(u_if.wrap), 8'(k == 2));
    end

    // Loads: in range, out of range, MOD-1, and load beating a wrapping count
    u_if.En   = 1'b0;
    u_if.load = 1'b1;
    u_if.D    = 4'd6;
    step();
    chk("ld6_q", 8'(u_if.Q), 8'd6);
    chk("ld6_tc", 8'(u_if.tc), 8'd0);
    u_if.D = 4'd12;
    step();
    chk("ld12_q", 8'(u_if.Q), 8'd0);
    chk("ld12_wrap", 8'(u_if.wrap), 8'd0);
    u_if.D = 4'd9;
    step();
    chk("ld9_q", 8'(u_if.Q), 8'd9);
    chk("ld9_wrap", 8'(u_if.wrap), 8'd0);
    u_if.load = 1'b0;
    u_if.En   = 1'b1;
    u_if.up   = 1'b1;
    #1;
    chk("tc_at9", 8'(u_if.tc), 8'd1);
    u_if.load = 1'b1;
    u_if.D    = 4'd3;
    #1;
    chk("tc_load_mask", 8'(u_if.tc), 8'd0);
    step();
    chk("ld_wins_q", 8'(u_if.Q), 8'd3);
    chk("ld_wins_wrap", 8'(u_if.wrap), 8'd0);

    // Hold with direction toggling
    u_if.En = 1'b0;
    u_if.D  = 4'd4;
    step();
    chk("ld4_q", 8'(u_if.Q), 8'd4);
    u_if.load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      u_if.up = ~u_if.up;
      step();
      chk("hold_q", 8'(u_if.Q), 8'd4);
      chk("hold_tc", 8'(u_if.tc), 8'd0);
      chk("hold_wrap", 8'(u_if.wrap), 8'd0);
    end

    // Two-digit cascade, 100 edges from 00
    cnt      = 0;
    hi_wraps = 0;
    u_lo.En  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      cnt = (cnt + 1) % 100;
      chk("casc_q", 8'(u_hi.Q) * 8'd10 + 8'(u_lo.Q), 8'(cnt));
      chk("casc_hi_wrap", 8'(u_hi.wrap), 8'(cnt == 0));
      if (u_hi.wrap) hi_wraps++;
    end
    chk("casc_end_hi", 8'(u_hi.Q), 8'd0);
    chk("casc_end_lo", 8'(u_lo.Q), 8'd0);
    chk("casc_hi_wrap_count", 8'(hi_wraps), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
